hex_syscall_unit: RTL
=====================

// Module: hex_syscall_unit
// PURPOSE
//  Responder for the processor's syscall request interface: accepts one syscall at a time and services it.
//  WRITE serialises a byte onto an 8N1 UART TX line. READ takes a byte from a valid/ready input stream.
//  EXIT latches a halt flag and exit code. Sits beside processor/memory in the hex top level,
//  driven by the processor's syscall valid/request outputs; completion is returned as a one-cycle response.
// PARAMETERS
//  DATA_W        32  width of syscall argument and response data
//  CLKS_PER_BIT  4   i_clk cycles per UART bit period; legal range >= 1
// PORTS
//  i_clk            in   1             clock
//  i_rst            in   1             synchronous reset, active high
//  i_syscall_valid  in   1             syscall request valid
//  o_syscall_ready  out  1             unit can accept a request
//  i_syscall_op     in   2             0=EXIT 1=WRITE 2=READ 3=reserved
//  i_syscall_arg    in   DATA_W        WRITE: byte in [7:0]; EXIT: exit code; READ: ignored
//  o_resp_valid     out  1             one-cycle completion pulse
//  o_resp_data      out  DATA_W        READ: zero-extended byte; WRITE: 0; reserved op: all ones
//  o_tx             out  1             UART serial out, idle high
//  i_rx_valid       in   1             input byte stream valid
//  o_rx_ready       out  1             input byte stream ready
//  i_rx_data        in   8             input byte
//  o_exit           out  1             sticky halt flag
//  o_exit_code      out  DATA_W        latched EXIT argument
// BEHAVIOUR
//  Reset values (synchronous, on any edge with i_rst=1):
//   state=IDLE, o_syscall_ready=1, o_tx=1, o_rx_ready=0, o_resp_valid=0, o_resp_data=0, o_exit=0, o_exit_code=0.
//  States: IDLE, TX, RD_WAIT, RESP, HALT. All outputs are registered.
//  Request accept:
//   - Accepted on the edge where i_syscall_valid & o_syscall_ready; op/arg are captured.
//   - o_syscall_ready is 1 only in IDLE; it drops on the cycle after accept.
//  WRITE:
//   - IDLE->TX. The 10 bit periods are the start bit (0), data[0]..data[7] (LSB first), and the stop bit (1).
//   - Each bit holds o_tx for exactly CLKS_PER_BIT cycles; bit and cycle counters are sized by $clog2.
//   - After the stop bit, TX->RESP. Accept at edge N gives o_resp_valid high in cycle N+1+10*CLKS_PER_BIT.
//   - arg[DATA_W-1:8] is ignored.
//  READ:
//   - IDLE->RD_WAIT, with o_rx_ready=1 while in RD_WAIT.
//   - A byte is captured on i_rx_valid & o_rx_ready; o_rx_ready drops the next cycle, then ->RESP.
//   - Waits indefinitely for i_rx_valid.
//  EXIT:
//   - IDLE->HALT. o_exit=1 and o_exit_code=arg from the cycle after accept.
//   - No response pulse. HALT is terminal until reset; ready stays 0 and o_tx stays 1.
//  Reserved op (3): IDLE->RESP with o_resp_data all ones.
//  RESP:
//   - o_resp_valid=1 for exactly one cycle, then ->IDLE. o_syscall_ready=1 the following cycle.
//   - o_resp_data holds its value until the next RESP or reset.
//  Boundaries:
//   - i_syscall_valid while busy is ignored (not queued).
//   - i_rx_valid outside RD_WAIT is not consumed.
//   - Reset mid-TX aborts the byte; o_tx=1 from the reset edge.
//   - Reset mid-RD_WAIT drops o_rx_ready without consuming.
//   - Reset in HALT clears o_exit and o_exit_code.
//   - CLKS_PER_BIT=1 must give exactly 1-cycle bits.
// TESTING
//  1. WRITE arg=0x41, CLKS_PER_BIT=4 -> o_tx 0,1,0,0,0,0,0,1,0,1 (4 cycles each);
//     o_resp_valid at accept+41, o_resp_data=0.
//  2. READ with i_rx_valid asserted 5 cycles late, i_rx_data=0xA5 -> one rx handshake;
//     o_resp_data=0x000000A5, single-cycle pulse.
//  3. EXIT arg=7 -> o_exit=1, o_exit_code=7; later requests never accepted (ready=0);
//     i_rst then clears both.
//  4. Back-to-back WRITE 0x00 then 0xFF with valid held high -> second accepted the cycle ready returns;
//     no gap errors, two resp pulses.
//  5. i_rst asserted mid-data-bit of WRITE -> o_tx=1, ready=1 after the reset edge;
//     a new WRITE 0x55 transmits correctly.
//  6. Op=3 -> o_resp_valid at accept+1 with o_resp_data=0xFFFFFFFF; o_tx never leaves 1.

Source files
------------

// File: rtl/hex_syscall_unit.sv
// ---------------------------------------------------------------------------
// hex_syscall_unit
//   Services one processor syscall at a time.
//     EXIT  (op 0) : latch sticky halt flag and exit code, park in HALT
//     WRITE (op 1) : send arg[7:0] as an 8N1 frame on o_tx, then respond 0
//     READ  (op 2) : take one byte from the rx valid/ready stream, respond
//                    with it zero-extended
//     op 3         : respond immediately with all ones
//   Every output comes straight from a flop. The *_d values are computed
//   from the next state, so each output changes on the same edge as the
//   state it belongs to.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_syscall_valid     request valid
//   o_syscall_ready     high only in IDLE
//   i_syscall_op        syscall opcode
//   i_syscall_arg       syscall argument
//   o_resp_valid        one-cycle completion pulse
//   o_resp_data         completion data, held until the next response
//   o_tx                UART serial out, idle high
//   i_rx_valid          rx byte stream valid
//   o_rx_ready          rx byte stream ready (only in RD_WAIT)
//   i_rx_data           rx byte
//   o_exit              sticky halt flag
//   o_exit_code         latched EXIT argument
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | ready for a request
// TX       | shifting a UART frame out on o_tx
// RD_WAIT  | o_rx_ready high, waiting for an input byte
// RESP     | o_resp_valid high for this single cycle
// HALT     | EXIT seen; terminal until reset
// ---------------------------------------------------------------------------
module hex_syscall_unit #(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_syscall_valid,
  output logic              o_syscall_ready,
  input  logic [1:0]        i_syscall_op,
  input  logic [DATA_W-1:0] i_syscall_arg,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_tx,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic [7:0]        i_rx_data,
  output logic              o_exit,
  output logic [DATA_W-1:0] o_exit_code
);

  // A one-bit counter is kept even when CLKS_PER_BIT is 1; the reload
  // value is then 0, so every bit still lasts a single cycle.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(10);
  localparam logic [CNT_W-1:0] CLK_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(9);

  localparam logic [1:0] OP_EXIT  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_RD_WAIT,
    ST_RESP,
    ST_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]        shift_q, shift_d;

  logic              ready_q, ready_d;
  logic              tx_q, tx_d;
  logic              rx_ready_q, rx_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              exit_q, exit_d;
  logic [DATA_W-1:0] exit_code_q, exit_code_d;

  logic accept;
  logic rx_fire;
  logic bit_end;

  assign accept  = i_syscall_valid & ready_q;
  assign rx_fire = i_rx_valid & rx_ready_q;
  assign bit_end = (state_q == ST_TX) && (clk_cnt_q == '0);

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '1;
      ready_q      <= 1'b1;
      tx_q         <= 1'b1;
      rx_ready_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      exit_q       <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ready_q      <= ready_d;
      tx_q         <= tx_d;
      rx_ready_q   <= rx_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      exit_q       <= exit_d;
      exit_code_q  <= exit_code_d;
    end
  end

  // Next state, bit timing and frame shifter
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (i_syscall_op)
            OP_EXIT:  state_d = ST_HALT;
            OP_WRITE: begin
              state_d   = ST_TX;
              clk_cnt_d = CLK_RELOAD;
              bit_cnt_d = '0;
              // Start bit goes out directly; the shifter holds the data
              // bits followed by the stop bit.
              shift_d   = {1'b1, i_syscall_arg[7:0]};
            end
            OP_READ:  state_d = ST_RD_WAIT;
            default:  state_d = ST_RESP;
          endcase
        end
      end
      ST_TX: begin
        if (clk_cnt_q == '0) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_RESP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            clk_cnt_d = CLK_RELOAD;
            shift_d   = {1'b1, shift_q[8:1]};
          end
        end else begin
          clk_cnt_d = clk_cnt_q - 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (rx_fire) state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered output values, derived from the state being entered
  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    rx_ready_d   = (state_d == ST_RD_WAIT);
    resp_valid_d = (state_d == ST_RESP);

    tx_d = 1'b1;
    if (state_d == ST_TX) begin
      if (state_q == ST_IDLE) tx_d = 1'b0;
      else if (bit_end)       tx_d = shift_q[0];
      else                    tx_d = tx_q;
    end

    resp_data_d = resp_data_q;
    if (state_d == ST_RESP && state_q != ST_RESP) begin
      unique case (state_q)
        ST_TX:      resp_data_d = '0;
        ST_RD_WAIT: resp_data_d = {{(DATA_W-8){1'b0}}, i_rx_data};
        default:    resp_data_d = '1;
      endcase
    end

    exit_d      = exit_q | (state_d == ST_HALT);
    exit_code_d = exit_code_q;
    if (state_q == ST_IDLE && state_d == ST_HALT) exit_code_d = i_syscall_arg;
  end

  assign o_syscall_ready = ready_q;
  assign o_tx            = tx_q;
  assign o_rx_ready      = rx_ready_q;
  assign o_resp_valid    = resp_valid_q;
  assign o_resp_data     = resp_data_q;
  assign o_exit          = exit_q;
  assign o_exit_code     = exit_code_q;

endmodule
